// File: rtl/ks_pkg.sv
// Shared definitions for the Kogge-Stone adder front-end and wrapper.
// Operand width and the operand-loader state encoding live here.
package ks_pkg;

   localparam int KS_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GOT_A   = 2'd1,
      PRESENT = 2'd2
   } ks_load_state_t;

   function automatic logic ks_state_busy(input ks_load_state_t state);
      return (state != IDLE);
   endfunction

endpackage

// File: rtl/ks_strobe_edge.sv
// Strobe rising-edge detector, one pulse per rise, gated by ena; optional
// KS_LOADER_SYNC_EN adds a SYNC_STAGES-deep synchronizer before the edge flop.
module ks_strobe_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic load_strobe,
   output logic pulse
);

   generate
      if (SYNC_STAGES >= 2 && SYNC_STAGES <= 3) begin : g_edge
         logic w_strobe_s;
         logic r_strobe_d;

`ifdef KS_LOADER_SYNC_EN
         logic [SYNC_STAGES-1:0] r_sync;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_sync <= '0;
            end else begin
               r_sync <= {r_sync[SYNC_STAGES-2:0], load_strobe};
            end
         end

         assign w_strobe_s = r_sync[SYNC_STAGES-1];
`else
         assign w_strobe_s = load_strobe;
`endif

         // Delay flop tracks the strobe even while ena is low, so a level
         // that rose during ena=0 never produces a late pulse.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_strobe_d <= 1'b0;
            end else begin
               r_strobe_d <= w_strobe_s;
            end
         end

         assign pulse = w_strobe_s & ~r_strobe_d & ena;
      end else begin : g_bad_depth
         assign pulse = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/ks_operand_loader.sv
// Serial A-then-B operand loader feeding the Kogge-Stone adder via valid/ready.
// Optional strobe synchronizer enabled by defining KS_LOADER_SYNC_EN.
module ks_operand_loader
   import ks_pkg::*;
#(
   parameter int WIDTH       = KS_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] din,
   input  logic             load_strobe,
   input  logic             clr_overrun,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_valid,
   input  logic             op_ready,
   output logic             busy,
   output logic             overrun
);

   ks_load_state_t   r_state;
   ks_load_state_t   w_state_nxt;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic             r_op_valid;
   logic             r_overrun;
   logic             w_pulse;
   logic             w_load_a;
   logic             w_load_b;
   logic             w_set_ovr;

   ks_strobe_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_strobe_edge (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .load_strobe (load_strobe),
      .pulse       (w_pulse)
   );

   // The handshake in PRESENT is not gated by ena: the adder downstream
   // must always be able to drain a presented pair.
   always_comb begin
      w_state_nxt = r_state;
      w_load_a    = 1'b0;
      w_load_b    = 1'b0;
      w_set_ovr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_pulse) begin
               w_load_a    = 1'b1;
               w_state_nxt = GOT_A;
            end
         end
         GOT_A: begin
            if (w_pulse) begin
               w_load_b    = 1'b1;
               w_state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            w_set_ovr = w_pulse;
            if (r_op_valid && op_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_op_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_op_valid <= (w_state_nxt == PRESENT);
         if (w_load_a) begin
            r_op_a <= din;
         end
         if (w_load_b) begin
            r_op_b <= din;
         end
      end
   end

   // A new overrun takes priority over a clear on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
      end else if (w_set_ovr) begin
         r_overrun <= 1'b1;
      end else if (clr_overrun) begin
         r_overrun <= 1'b0;
      end
   end

   assign op_a     = r_op_a;
   assign op_b     = r_op_b;
   assign op_valid = r_op_valid;
   assign busy     = ks_state_busy(r_state);
   assign overrun  = r_overrun;

endmodule

// File: doc/ks_operand_loader.md
Name: ks_operand_loader

Overview:
- Upstream front-end for the 8-bit Kogge-Stone adder.
- The pin budget allows only 8 input pins, so full 8-bit operands are loaded serially over the same bus: A first, then B.
- Each byte is qualified by a strobe pin.
- The block registers both operands and presents them to the adder stage with a valid/ready handshake.

Parameters:
- WIDTH, 8, operand width in bits; must equal the din width.
- SYNC_STAGES, 2, synchronizer depth on the strobe; used only when KS_LOADER_SYNC_EN is defined; legal values 2..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low freezes the FSM and ignores strobes
- din  in  WIDTH  operand byte from the input pins
- load_strobe  in  1  rising edge marks din as valid
- clr_overrun  in  1  synchronous clear of the overrun flag
- op_a  out  WIDTH  registered operand A
- op_b  out  WIDTH  registered operand B
- op_valid  out  1  op_a/op_b are a complete pair
- op_ready  in  1  adder stage accepts the pair
- busy  out  1  high in GOT_A or PRESENT
- overrun  out  1  sticky: a strobe arrived while in PRESENT

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs and internal registers are 0; state = IDLE.
- Strobe detection:
  - strobe_s is the (optionally synchronized) strobe.
  - strobe_d is strobe_s delayed by one flop.
  - pulse = strobe_s & ~strobe_d & ena.
  - Exactly one pulse per rising edge; a level held high gives no further pulses.
- FSM states: IDLE, GOT_A, PRESENT.
  - IDLE, pulse: op_a <= din; go to GOT_A.
  - GOT_A, pulse: op_b <= din; go to PRESENT; op_valid = 1 from the next cycle.
  - PRESENT: op_valid = 1. op_a and op_b hold stable until handshake.
  - PRESENT, op_valid & op_ready at a clock edge: pair consumed; go to IDLE; op_valid drops the next cycle.
  - op_a and op_b keep their last values after the handshake; they are not cleared.
- Outputs:
  - op_valid is a registered output, not combinational from op_ready.
  - busy = (state != IDLE).
- Overrun and boundary cases:
  - Pulse in PRESENT with no handshake that edge: the byte is dropped; overrun <= 1; operands unchanged.
  - Pulse in PRESENT on the same edge as the handshake: go to IDLE; the byte is dropped; overrun <= 1. The next byte is not treated as A.
  - clr_overrun and a new overrun on the same edge: set wins.
- ena low:
  - No pulses are generated; state and registers hold.
  - op_valid stays asserted if it already was, and the handshake still completes. The adder sits downstream and is not gated by ena.
- Reset mid-operation: asserting rst_n low in any state returns the block to IDLE immediately, asynchronously. A partial A is discarded.
- Width: op_a and op_b are plain registers; no arithmetic is performed in this block.

Optional Feature:
- KS_LOADER_SYNC_EN defined:
  - load_strobe passes through a SYNC_STAGES-flop synchronizer before edge detection.
  - Capture occurs SYNC_STAGES+1 clock edges after the strobe's rise is first sampled.
  - The source must hold din stable for at least SYNC_STAGES+2 cycles after raising the strobe.
- Not defined:
  - strobe_s = load_strobe; the strobe is assumed synchronous to clk.
  - Capture occurs on the first edge after the strobe is sampled high.

Decomposition:
- Shared package ks_pkg:
  - KS_WIDTH = 8.
  - FSM state enum ks_load_state_t {IDLE, GOT_A, PRESENT} as a 2-bit encoding.
  - The package is reused by the adder wrapper.
- One sub-module, ks_strobe_edge:
  - Contains the optional synchronizer, strobe_d and pulse generation.
  - Inputs: clk, rst_n, ena, load_strobe.
  - Output: pulse.
- The FSM and operand registers stay in ks_operand_loader.

Test Plan:
- Basic load: reset; strobe with din=0xA5, then din=0x3C; op_ready=1 → op_valid rises one cycle after the second capture with op_a=0xA5, op_b=0x3C; busy returns to 0 one cycle after the handshake.
- Backpressure: same load with op_ready=0 for 5 cycles, then 1 → op_valid stays 1 and operands stay 0xA5/0x3C for all 5 cycles; a single handshake occurs.
- Overrun: in PRESENT, strobe din=0x77 → overrun=1, op_a/op_b unchanged; clr_overrun pulse → overrun=0.
- ena gating: ena=0 while strobing 0x11 → state stays IDLE, op_a=0x00; ena=1 then strobe 0x11 → op_a=0x11.
- Reset mid-load: capture A=0xFF, assert rst_n=0 in GOT_A → op_a=0x00, busy=0 immediately; next strobe is captured as A.
- Strobe level held high for 10 cycles → exactly one capture. With KS_LOADER_SYNC_EN, the capture is delayed by SYNC_STAGES cycles relative to a build without it.
